tt_fpga_adapter: RTL and testbench

Board-side adapter between FPGA pins and a Tiny Tapeout project core. It generates a divided project clock with a programmable ratio. It sequences the project reset so it releases cleanly on the divided clock. Inputs are synchronised, and outputs plus bidirectional enables are registered. The board top instantiates it directly under the pads, and it resolves the tri-state as `pad = pad_uio_oe ? pad_uio_o : z`.

---
 rtl/tt_fpga_adapter.sv | 178 +++++++++++++++++
 tb/tb_tt_fpga_adapter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_fpga_adapter.sv
// Tiny Tapeout board adapter: divided proj_clk, sequenced proj_rst_n, synchronised inputs, registered outputs; TT_ADAPTER_DEBOUNCE_EN adds a proj_ui filter.
// Latency: inputs SYNC_STAGES clk (+DEBOUNCE when filtered), outputs 1 clk; no backpressure, every pin is sampled on every clk.
module tt_fpga_adapter #(
    parameter int WIDTH       = 8,
    parameter int DIV         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int RST_HOLD    = 16,
    parameter int DEBOUNCE    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_ui,
    output logic [WIDTH-1:0] pad_uo,
    input  logic [WIDTH-1:0] pad_uio_i,
    output logic [WIDTH-1:0] pad_uio_o,
    output logic [WIDTH-1:0] pad_uio_oe,
    output logic             proj_clk,
    output logic             proj_rst_n,
    output logic [WIDTH-1:0] proj_ui,
    input  logic [WIDTH-1:0] proj_uo,
    output logic [WIDTH-1:0] proj_uio_in,
    input  logic [WIDTH-1:0] proj_uio_out,
    input  logic [WIDTH-1:0] proj_uio_oe,
    output logic             locked
);

    localparam int CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_N   = HOLD_W'(RST_HOLD);
    localparam bit PARAMS_OK = (DIV >= 2) && (DIV % 2 == 0) && (SYNC_STAGES >= 2)
                               && (RST_HOLD >= 1) && (DEBOUNCE >= 1);

    if (!PARAMS_OK) begin : g_illegal_parameters
        // Only elaborated for an unsupported configuration; the block name surfaces it in the hierarchy.
    end

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SYNC  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   rise_cnt_q, rise_cnt_d;
    logic                proj_clk_q, proj_clk_d;
    logic                proj_rst_n_q, proj_rst_n_d;
    logic [1:0]          rst_sync_q;
    logic                toggle, rise_evt, fall_evt;
    logic [WIDTH-1:0]    ui_sync_q  [SYNC_STAGES];
    logic [WIDTH-1:0]    uio_sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    pad_uo_q, pad_uio_o_q, pad_uio_oe_q;

    // Toggling at the half and full count gives a 50% duty clock of period DIV.
    assign toggle     = (cnt_q == CNT_HALF) || (cnt_q == CNT_LAST);
    assign cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    assign proj_clk_d = proj_clk_q ^ toggle;
    assign rise_evt   = toggle & ~proj_clk_q;
    assign fall_evt   = toggle & proj_clk_q;

    always_comb begin
        state_d    = state_q;
        rise_cnt_d = rise_cnt_q;
        case (state_q)
            ST_RESET: state_d = ST_SYNC;
            ST_SYNC: begin
                if (rst_sync_q[1]) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Release only on a falling proj_clk edge so the core never sees reset and a rising edge together.
                if (rise_cnt_q == HOLD_N) begin
                    if (fall_evt) begin
                        state_d = ST_RUN;
                    end
                end else if (rise_evt) begin
                    rise_cnt_d = rise_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RESET;
        endcase
    end

    assign proj_rst_n_d = (state_d == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            rise_cnt_q   <= '0;
            proj_clk_q   <= 1'b0;
            proj_rst_n_q <= 1'b0;
            rst_sync_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rise_cnt_q   <= rise_cnt_d;
            proj_clk_q   <= proj_clk_d;
            proj_rst_n_q <= proj_rst_n_d;
            rst_sync_q   <= {rst_sync_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ui_sync_q[i]  <= '0;
                uio_sync_q[i] <= '0;
            end
        end else begin
            ui_sync_q[0]  <= pad_ui;
            uio_sync_q[0] <= pad_uio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ui_sync_q[i]  <= ui_sync_q[i-1];
                uio_sync_q[i] <= uio_sync_q[i-1];
            end
        end
    end

    // Data and enable share one register stage so a new enable never meets stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_uo_q     <= '0;
            pad_uio_o_q  <= '0;
            pad_uio_oe_q <= '0;
        end else begin
            pad_uo_q     <= proj_uo;
            pad_uio_o_q  <= proj_uio_out;
            pad_uio_oe_q <= proj_rst_n_q ? proj_uio_oe : '0;
        end
    end

`ifdef TT_ADAPTER_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [DB_W-1:0]  db_cnt_q [WIDTH];
    logic [WIDTH-1:0] db_ui_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_ui_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ui_sync_q[SYNC_STAGES-1][i] == db_ui_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_ui_q[i]  <= ui_sync_q[SYNC_STAGES-1][i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign proj_ui = db_ui_q;
`else
    assign proj_ui = ui_sync_q[SYNC_STAGES-1];
`endif

    assign proj_uio_in = uio_sync_q[SYNC_STAGES-1];
    assign proj_clk    = proj_clk_q;
    assign proj_rst_n  = proj_rst_n_q;
    assign locked      = (state_q == ST_RUN);
    assign pad_uo      = pad_uo_q;
    assign pad_uio_o   = pad_uio_o_q;
    assign pad_uio_oe  = pad_uio_oe_q;

endmodule

// File: tb/tb_tt_fpga_adapter.sv
// Bench for tt_fpga_adapter: main instance DIV=4/RST_HOLD=3, plus DIV=2 and DIV=6 instances for divider timing.
`timescale 1ns/1ps
module tb_tt_fpga_adapter;
    localparam int W     = 8;
    localparam int MDIV  = 4;
    localparam int MHOLD = 3;
`ifdef TT_ADAPTER_DEBOUNCE_EN
    localparam int UI_LAT = 2 + 4;
`else
    localparam int UI_LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pad_ui, pad_uio_i, proj_uo, proj_uio_out, proj_uio_oe;
    logic [W-1:0] pad_uo, pad_uio_o, pad_uio_oe, proj_ui, proj_uio_in;
    logic         proj_clk, proj_rst_n, locked;
    logic [W-1:0] d2_uo, d2_uio_o, d2_uio_oe, d2_ui, d2_uio_in;
    logic         d2_clk, d2_rst_n, d2_locked;
    logic [W-1:0] d6_uo, d6_uio_o, d6_uio_oe, d6_ui, d6_uio_in;
    logic         d6_clk, d6_rst_n, d6_locked;

    int total = 0;
    int bad   = 0;
    int rel_first, rel_second;

    logic [W-1:0] q_ui[$], q_uio[$], q_uo[$], q_uio_o[$], q_oe[$];
    logic         q_c2[$], q_c4[$], q_c6[$];

    tt_fpga_adapter #(.WIDTH(W), .DIV(MDIV), .SYNC_STAGES(2), .RST_HOLD(MHOLD), .DEBOUNCE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .pad_ui(pad_ui), .pad_uo(pad_uo), .pad_uio_i(pad_uio_i),
        .pad_uio_o(pad_uio_o), .pad_uio_oe(pad_uio_oe), .proj_clk(proj_clk), .proj_rst_n(proj_rst_n),
        .proj_ui(proj_ui), .proj_uo(proj_uo), .proj_uio_in(proj_uio_in), .proj_uio_out(proj_uio_out),
        .proj_uio_oe(proj_uio_oe), .locked(locked));

    tt_fpga_adapter #(.WIDTH(W), .DIV(2)) u_div2 (
        .clk(clk), .rst_n(rst_n), .pad_ui(pad_ui), .pad_uo(d2_uo), .pad_uio_i(pad_uio_i),
        .pad_uio_o(d2_uio_o), .pad_uio_oe(d2_uio_oe), .proj_clk(d2_clk), .proj_rst_n(d2_rst_n),
        .proj_ui(d2_ui), .proj_uo(proj_uo), .proj_uio_in(d2_uio_in), .proj_uio_out(proj_uio_out),
        .proj_uio_oe(proj_uio_oe), .locked(d2_locked));

    tt_fpga_adapter #(.WIDTH(W), .DIV(6)) u_div6 (
        .clk(clk), .rst_n(rst_n), .pad_ui(pad_ui), .pad_uo(d6_uo), .pad_uio_i(pad_uio_i),
        .pad_uio_o(d6_uio_o), .pad_uio_oe(d6_uio_oe), .proj_clk(d6_clk), .proj_rst_n(d6_rst_n),
        .proj_ui(d6_ui), .proj_uo(proj_uo), .proj_uio_in(d6_uio_in), .proj_uio_out(proj_uio_out),
        .proj_uio_oe(proj_uio_oe), .locked(d6_locked));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // proj_clk level after clk edge k: one toggle every DIV/2 edges, starting low.
    function automatic logic exp_level(input int k, input int d);
        return logic'((k / (d / 2)) % 2);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        pad_ui = '1; pad_uio_i = '1; proj_uo = '1; proj_uio_out = '1; proj_uio_oe = '1;
        repeat (3) tick();
        total += 10;
        if (proj_clk !== 1'b0)   begin bad++; $display("FAIL rst_proj_clk got=%b want=0", proj_clk); end
        if (proj_rst_n !== 1'b0) begin bad++; $display("FAIL rst_proj_rst_n got=%b want=0", proj_rst_n); end
        if (locked !== 1'b0)     begin bad++; $display("FAIL rst_locked got=%b want=0", locked); end
        if (pad_uo !== '0)       begin bad++; $display("FAIL rst_pad_uo got=%h want=00", pad_uo); end
        if (pad_uio_o !== '0)    begin bad++; $display("FAIL rst_pad_uio_o got=%h want=00", pad_uio_o); end
        if (pad_uio_oe !== '0)   begin bad++; $display("FAIL rst_pad_uio_oe got=%h want=00", pad_uio_oe); end
        if (proj_ui !== '0)      begin bad++; $display("FAIL rst_proj_ui got=%h want=00", proj_ui); end
        if (proj_uio_in !== '0)  begin bad++; $display("FAIL rst_proj_uio_in got=%h want=00", proj_uio_in); end
        if (d2_clk !== 1'b0)     begin bad++; $display("FAIL rst_div2_clk got=%b want=0", d2_clk); end
        if (d6_clk !== 1'b0)     begin bad++; $display("FAIL rst_div6_clk got=%b want=0", d6_clk); end
        pad_ui = '0; pad_uio_i = '0; proj_uio_out = '0;
    endtask

    // Called just after a clk edge; releases rst_n and follows the whole bring-up.
    task automatic test_sequencer(output int rel_edge);
        logic prev_clk;
        logic e;
        rel_edge = -1;
        prev_clk = proj_clk;
        proj_uio_oe = '1;
        proj_uo = 8'h5A;
        q_c2.delete(); q_c4.delete(); q_c6.delete();
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            q_c2.push_back(exp_level(k, 2));
            q_c4.push_back(exp_level(k, MDIV));
            q_c6.push_back(exp_level(k, 6));
            tick();
            total += 4;
            e = q_c2.pop_front();
            if (d2_clk !== e)    begin bad++; $display("FAIL div2_clk edge=%0d got=%b want=%b", k, d2_clk, e); end
            e = q_c4.pop_front();
            if (proj_clk !== e)  begin bad++; $display("FAIL div4_clk edge=%0d got=%b want=%b", k, proj_clk, e); end
            e = q_c6.pop_front();
            if (d6_clk !== e)    begin bad++; $display("FAIL div6_clk edge=%0d got=%b want=%b", k, d6_clk, e); end
            if (locked !== proj_rst_n) begin
                bad++; $display("FAIL locked_vs_rst edge=%0d got=%b want=%b", k, locked, proj_rst_n);
            end
            if (proj_rst_n !== 1'b1) begin
                total++;
                if (pad_uio_oe !== '0) begin bad++; $display("FAIL oe_in_reset edge=%0d got=%h want=00", k, pad_uio_oe); end
            end else if (rel_edge < 0) begin
                rel_edge = k;
                total++;
                if (!(prev_clk === 1'b1 && proj_clk === 1'b0)) begin
                    bad++; $display("FAIL release_on_fall edge=%0d got=%b->%b want=1->0", k, prev_clk, proj_clk);
                end
            end
            prev_clk = proj_clk;
        end
        total += 3;
        if (rel_edge < 0) begin
            bad++; $display("FAIL release_timeout got=none want=release within 40 edges");
        end else if (rel_edge < 2 + MHOLD * MDIV || rel_edge > 2 + (MHOLD + 2) * MDIV) begin
            bad++; $display("FAIL release_edge got=%0d want=%0d..%0d", rel_edge, 2 + MHOLD * MDIV, 2 + (MHOLD + 2) * MDIV);
        end
        if (pad_uio_oe !== 8'hFF) begin bad++; $display("FAIL oe_after_release got=%h want=ff", pad_uio_oe); end
        if (pad_uo !== 8'h5A)     begin bad++; $display("FAIL pad_uo_follow got=%h want=5a", pad_uo); end
    endtask

    task automatic test_sync();
        logic [W-1:0] e;
        q_ui.delete(); q_uio.delete();
        pad_ui = 8'hA5;    q_ui.push_back(8'hA5);
        pad_uio_i = 8'h96; q_uio.push_back(8'h96);
        for (int k = 1; k <= UI_LAT; k++) begin
            tick();
            total++;
            if (k < 2) begin
                if (proj_uio_in !== 8'h00) begin bad++; $display("FAIL uio_sync_early edge=%0d got=%h want=00", k, proj_uio_in); end
            end else if (k == 2) begin
                e = q_uio.pop_front();
                if (proj_uio_in !== e) begin bad++; $display("FAIL uio_sync edge=%0d got=%h want=%h", k, proj_uio_in, e); end
            end else begin
                total--;
            end
            total++;
            if (k < UI_LAT) begin
                if (proj_ui !== 8'h00) begin bad++; $display("FAIL ui_sync_early edge=%0d got=%h want=00", k, proj_ui); end
            end else begin
                e = q_ui.pop_front();
                if (proj_ui !== e) begin bad++; $display("FAIL ui_sync edge=%0d got=%h want=%h", k, proj_ui, e); end
            end
        end
    endtask

    task automatic test_output_reg();
        logic [W-1:0] e;
        q_oe.delete(); q_uio_o.delete();
        proj_uio_oe = 8'h0F;  q_oe.push_back(8'h0F);
        proj_uio_out = 8'h3C; q_uio_o.push_back(8'h3C);
        tick();
        total += 2;
        e = q_oe.pop_front();
        if (pad_uio_oe !== e) begin bad++; $display("FAIL out_oe got=%h want=%h", pad_uio_oe, e); end
        e = q_uio_o.pop_front();
        if (pad_uio_o !== e)  begin bad++; $display("FAIL out_data got=%h want=%h", pad_uio_o, e); end
        proj_uio_oe = 8'h00; q_oe.push_back(8'h00);
        tick();
        total++;
        e = q_oe.pop_front();
        if (pad_uio_oe !== e) begin bad++; $display("FAIL out_oe_drop got=%h want=%h", pad_uio_oe, e); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, v;
        q_ui.delete(); q_uio.delete(); q_uo.delete(); q_uio_o.delete(); q_oe.delete();
        for (int c = 0; c < 24; c++) begin
            v = W'($urandom); proj_uo = v;      q_uo.push_back(v);
            v = W'($urandom); proj_uio_out = v; q_uio_o.push_back(v);
            v = W'($urandom); proj_uio_oe = v;  q_oe.push_back(v);
            v = W'($urandom); pad_uio_i = v;    q_uio.push_back(v);
`ifndef TT_ADAPTER_DEBOUNCE_EN
            v = W'($urandom); pad_ui = v;       q_ui.push_back(v);
`endif
            tick();
            total += 3;
            e = q_uo.pop_front();
            if (pad_uo !== e)     begin bad++; $display("FAIL b2b_uo c=%0d got=%h want=%h", c, pad_uo, e); end
            e = q_uio_o.pop_front();
            if (pad_uio_o !== e)  begin bad++; $display("FAIL b2b_uio_o c=%0d got=%h want=%h", c, pad_uio_o, e); end
            e = q_oe.pop_front();
            if (pad_uio_oe !== e) begin bad++; $display("FAIL b2b_oe c=%0d got=%h want=%h", c, pad_uio_oe, e); end
            if (q_uio.size() == 2) begin
                total++;
                e = q_uio.pop_front();
                if (proj_uio_in !== e) begin bad++; $display("FAIL b2b_uio_in c=%0d got=%h want=%h", c, proj_uio_in, e); end
            end
            if (q_ui.size() == 2) begin
                total++;
                e = q_ui.pop_front();
                if (proj_ui !== e) begin bad++; $display("FAIL b2b_ui c=%0d got=%h want=%h", c, proj_ui, e); end
            end
        end
    endtask

    task automatic test_mid_reset();
        proj_uo = 8'hC3; proj_uio_out = 8'h81; proj_uio_oe = 8'hFF; pad_ui = 8'h77; pad_uio_i = 8'h66;
        repeat (8) tick();
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL mid_pre_locked got=%b want=1", locked); end
        #3;
        rst_n = 1'b0;
        #1;
        total += 8;
        if (proj_clk !== 1'b0)   begin bad++; $display("FAIL mid_proj_clk got=%b want=0", proj_clk); end
        if (proj_rst_n !== 1'b0) begin bad++; $display("FAIL mid_proj_rst_n got=%b want=0", proj_rst_n); end
        if (locked !== 1'b0)     begin bad++; $display("FAIL mid_locked got=%b want=0", locked); end
        if (pad_uo !== '0)       begin bad++; $display("FAIL mid_pad_uo got=%h want=00", pad_uo); end
        if (pad_uio_o !== '0)    begin bad++; $display("FAIL mid_pad_uio_o got=%h want=00", pad_uio_o); end
        if (pad_uio_oe !== '0)   begin bad++; $display("FAIL mid_pad_uio_oe got=%h want=00", pad_uio_oe); end
        if (proj_ui !== '0)      begin bad++; $display("FAIL mid_proj_ui got=%h want=00", proj_ui); end
        if (proj_uio_in !== '0)  begin bad++; $display("FAIL mid_proj_uio_in got=%h want=00", proj_uio_in); end
        repeat (2) tick();
        pad_ui = '0; pad_uio_i = '0;
    endtask

`ifdef TT_ADAPTER_DEBOUNCE_EN
    task automatic test_debounce();
        pad_ui = 8'h00;
        repeat (10) tick();
        total++;
        if (proj_ui[0] !== 1'b0) begin bad++; $display("FAIL db_idle got=%b want=0", proj_ui[0]); end
        pad_ui[0] = 1'b1;
        repeat (3) tick();
        pad_ui[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (proj_ui[0] !== 1'b0) begin bad++; $display("FAIL db_glitch edge=%0d got=%b want=0", k, proj_ui[0]); end
        end
        pad_ui[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++;
            if (proj_ui[0] !== logic'(k >= 6)) begin
                bad++; $display("FAIL db_hold edge=%0d got=%b want=%b", k, proj_ui[0], logic'(k >= 6));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequencer(rel_first);
        test_sync();
        test_output_reg();
        test_back_to_back();
        test_mid_reset();
        test_sequencer(rel_second);
        total++;
        if (rel_second !== rel_first) begin
            bad++; $display("FAIL rerun_release got=%0d want=%0d", rel_second, rel_first);
        end
`ifdef TT_ADAPTER_DEBOUNCE_EN
        test_debounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
